// File: rtl/t03_muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide over 32 iterations, with sign fix-up and a one-cycle done pulse.
module t03_muldiv_seq (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic        flush,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  typedef struct packed {
    logic [2:0] f3;
    logic       a_neg;
    logic       b_neg;
  } op_t;

  state_t      state, state_nxt;
  op_t         op;
  logic [5:0]  cnt;
  logic [63:0] acc;
  logic [31:0] quot;
  logic [31:0] a_mag, b_mag;

  // Start-edge decode
  logic        is_div, a_sgn, b_sgn, a_neg_in, b_neg_in;
  logic        div_zero, div_ovf, fast, accept;
  logic [31:0] fast_res;

  always_comb begin
    is_div   = funct3[2];
    a_sgn    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sgn    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg_in = a_sgn & rs1[31];
    b_neg_in = b_sgn & rs2[31];
    div_zero = is_div && (rs2 == 32'd0);
    div_ovf  = is_div && !funct3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_res = funct3[1] ? rs1 : 32'hFFFF_FFFF;
    else          fast_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    accept   = (state == IDLE) && start && !flush;
  end

  // One iteration of multiply or divide
  logic [32:0] sum33;
  logic [32:0] rem_sh, trial;
  logic        q_bit;
  logic [31:0] rem_new;
  logic [63:0] acc_mul;

  always_comb begin
    sum33   = {1'b0, acc[63:32]} + (b_mag[0] ? {1'b0, a_mag} : 33'd0);
    acc_mul = {sum33, acc[31:1]};
    rem_sh  = {acc[63:32], a_mag[31]};
    trial   = rem_sh - {1'b0, b_mag};
    // A shifted remainder with bit 32 set always exceeds the divisor.
    q_bit   = rem_sh[32] | ~trial[32];
    rem_new = q_bit ? trial[31:0] : rem_sh[31:0];
  end

  // Sign fix-up and result selection
  logic [63:0] prod_f;
  logic [31:0] quot_f, rem_f, fix_res;

  always_comb begin
    prod_f = (op.a_neg ^ op.b_neg) ? (64'd0 - acc) : acc;
    quot_f = (op.a_neg ^ op.b_neg) ? (32'd0 - quot) : quot;
    rem_f  = op.a_neg ? (32'd0 - acc[63:32]) : acc[63:32];
    case (op.f3)
      3'b000:                 fix_res = prod_f[31:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_f[63:32];
      3'b100, 3'b101:         fix_res = quot_f;
      default:                fix_res = rem_f;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = fast ? DONE : CALC;
      CALC:    if (cnt == 6'd31) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      op     <= '0;
      cnt    <= '0;
      acc    <= '0;
      quot   <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      result <= '0;
    end else if (accept) begin
      op     <= '{f3: funct3, a_neg: a_neg_in, b_neg: b_neg_in};
      a_mag  <= a_neg_in ? (32'd0 - rs1) : rs1;
      b_mag  <= b_neg_in ? (32'd0 - rs2) : rs2;
      cnt    <= '0;
      acc    <= '0;
      quot   <= '0;
      if (fast) result <= fast_res;
    end else if (!flush && state == CALC) begin
      cnt <= cnt + 6'd1;
      if (op.f3[2]) begin
        acc   <= {rem_new, acc[31:0]};
        a_mag <= {a_mag[30:0], 1'b0};
        quot  <= {quot[30:0], q_bit};
      end else begin
        acc   <= acc_mul;
        b_mag <= {1'b0, b_mag[31:1]};
      end
    end else if (!flush && state == FIX) begin
      result <= fix_res;
    end
  end

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

endmodule

// File: tb/tb_t03_muldiv_seq.sv
// Directed plus randomized checks of t03_muldiv_seq against an arithmetic reference model.
module tb_t03_muldiv_seq;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic [31:0] result;
  logic        busy, done;

  int npass = 0;
  int ntot  = 0;
  logic [31:0] last_exp;

  t03_muldiv_seq dut (
    .clk(clk), .nrst(nrst), .start(start), .flush(flush), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference: RV32M semantics computed with wide integer arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] c [5];
    c = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Issue one op, check latency, busy duration, result, and single-cycle done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    bit fst;
    int lat, bcnt;
    exp = ref_md(f, a, b);
    fst = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom);
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, fst ? 32'd0 : 32'd33);
    chk({tag, " busy_cycles"}, bcnt, fst ? 32'd0 : 32'd33);
    chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, " result"}, result, exp);
    last_exp = exp;
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat, dcnt;
    nrst = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'd0; rs1 = '0; rs2 = '0;
    #1;
    chk("reset result", result, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_neg");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_max");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_neg");
    run_op(3'd5, 32'd100, 32'd7, "divu");
    run_op(3'd7, 32'd100, 32'd7, "remu");
    run_op(3'd4, 32'd5, 32'd0, "div_by0");
    run_op(3'd7, 32'd5, 32'd0, "remu_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(3'd5, 32'hFFFF_FFFF, 32'd1, "divu_big");

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), pick(), pick(), $sformatf("rand%0d", i));

    // start during CALC is ignored
    funct3 = 3'd0; rs1 = 32'd1234; rs2 = 32'd5678; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1; funct3 = 3'd5; rs1 = 32'd99; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 11;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("ign_start latency", lat, 32'd33);
    chk("ign_start result", result, ref_md(3'd0, 32'd1234, 32'd5678));
    last_exp = ref_md(3'd0, 32'd1234, 32'd5678);
    @(posedge clk); #1;

    // flush at cycle 5 of CALC
    funct3 = 3'd1; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush done", {31'd0, done}, 32'd0);
    chk("flush result", result, last_exp);
    dcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dcnt++; end
    chk("flush no_done", dcnt, 32'd0);
    chk("flush result_hold", result, last_exp);

    // asynchronous reset mid-CALC
    funct3 = 3'd0; rs1 = 32'd77; rs2 = 32'd88; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3; nrst = 1'b0;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst done", {31'd0, done}, 32'd0);
    chk("arst result", result, 32'd0);
    #3; nrst = 1'b1;
    @(posedge clk); #1;
    run_op(3'd0, 32'd3, 32'd4, "mul_after_rst");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
